// File: rtl/clock_period_meter.sv
// Half-period meter for a slow toggle signal: synchronizes sig_in, measures the distance between
// edges in clk_in cycles, declares lock on a stable rate and flags a sticky timeout when edges stop.
module clock_period_meter #(
  parameter int MAX_COUNT  = 1024,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic [1:0]       state_dbg
);

  // period_valid is a one-cycle strobe with no ready: the consumer must take half_period
  // in the cycle period_valid is high, there is no back-pressure.

  localparam int M_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_COUNT);
  localparam logic [M_W-1:0]   LOCK_M = M_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] hp_cnt;
  logic [M_W-1:0]   match;
  logic             edge_det, rise, fall;

  assign edge_det  = s2 ^ s3;
  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign state_dbg = state;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      hp_cnt       <= '0;
      match        <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
    end else begin
      // Synchronizer keeps running in IDLE so no stale edge appears when enable rises.
      s1           <= sig_in;
      s2           <= s1;
      s3           <= s2;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period_valid <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        hp_cnt  <= '0;
        match   <= '0;
        locked  <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            hp_cnt <= '0;
            match  <= '0;
            locked <= 1'b0;
            state  <= ACQUIRE;
          end
          default: begin
            rise_pulse <= rise;
            fall_pulse <= fall;
            if (edge_det) begin
              // An edge wins over saturation, so a MAX_COUNT interval is a valid measurement.
              hp_cnt  <= CNT_W'(1);
              timeout <= 1'b0;
              if (state == ACQUIRE) begin
                state <= MEASURE;
              end else begin
                half_period  <= hp_cnt;
                period_valid <= 1'b1;
                if (hp_cnt == half_period) begin
                  if (match >= LOCK_M - M_W'(1)) begin
                    match  <= LOCK_M;
                    locked <= 1'b1;
                    state  <= LOCKED;
                  end else begin
                    match <= match + M_W'(1);
                  end
                end else begin
                  match  <= M_W'(1);
                  locked <= 1'b0;
                  state  <= MEASURE;
                end
              end
            end else if (hp_cnt == MAX_C) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              match   <= '0;
              state   <= ACQUIRE;
            end else begin
              hp_cnt <= hp_cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares every period_valid strobe.
module tb_clock_period_meter;

  localparam int MAXC  = 16;
  localparam int LOCKC = 4;
  localparam int CW    = 5;
  localparam int EW    = CW + 2;

  logic          clk_in = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          sig_in;
  logic          rise_pulse, fall_pulse, period_valid, locked, timeout;
  logic [CW-1:0] half_period;
  logic [1:0]    state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rise_cnt = 0, fall_cnt = 0, exp_rise = 0, exp_fall = 0;

  clock_period_meter #(.MAX_COUNT(MAXC), .LOCK_COUNT(LOCKC), .CNT_W(CW)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .half_period(half_period),
    .period_valid(period_valid), .locked(locked), .timeout(timeout), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h", name, act, req);
    end
  endtask

  // driver: toggle sig_in gap cycles after the previous toggle, optionally expecting a strobe
  task automatic send_edge(input int gap, input bit v, input logic [CW-1:0] hp, input bit lk);
    repeat (gap) @(posedge clk_in);
    #1;
    sig_in = ~sig_in;
    if (sig_in) exp_rise++;
    else exp_fall++;
    if (v) exp_q.push_back({1'b0, lk, hp});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk_in);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk_in) begin
    if (rise_pulse) rise_cnt++;
    if (fall_pulse) fall_cnt++;
    if (period_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: act hp=%0d locked=%0b req=no strobe", half_period, locked);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("strobe {timeout,locked,half_period}", {timeout, locked, half_period}, e);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_half_period", half_period, 0);
    check("reset_flags", {period_valid, locked, timeout, rise_pulse, fall_pulse}, 0);
    check("reset_state", state_dbg, 0);
    reset_n = 1'b1;
    enable  = 1'b1;

    // T1: 4-cycle toggles, lock on 4th strobe
    send_edge(4, 0, 0, 0);
    for (int i = 1; i <= 4; i++) send_edge(4, 1, 4, i == 4);
    // T2: switch to 6, unlock then relock
    for (int i = 1; i <= 4; i++) send_edge(6, 1, 6, i == 4);

    // T3: stop toggling; timeout 16 cycles after the last detected edge
    repeat (18) @(posedge clk_in);
    #1;
    check("t3_pre_timeout", timeout, 0);
    check("t3_pre_locked", locked, 1);
    @(posedge clk_in);
    #1;
    check("t3_timeout", timeout, 1);
    check("t3_locked_cleared", locked, 0);
    check("t3_state_acquire", state_dbg, 1);
    check("t3_queue_empty", exp_q.size(), 0);
    send_edge(3, 0, 0, 0);

    // T4: edges exactly MAX_COUNT apart; timeout cleared and stays 0 at each strobe
    for (int i = 1; i <= 4; i++) send_edge(16, 1, 16, i == 4);

    // T5: relock at 4, then reset mid-interval
    for (int i = 1; i <= 4; i++) send_edge(4, 1, 4, i == 4);
    repeat (4) @(posedge clk_in);
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_async_half_period", half_period, 0);
    check("t5_async_flags", {period_valid, locked, timeout, rise_pulse, fall_pulse}, 0);
    check("t5_async_state", state_dbg, 0);
    check("t5_queue_empty", exp_q.size(), 0);
    sig_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk_in);
    send_edge(4, 0, 0, 0);
    for (int i = 1; i <= 4; i++) send_edge(4, 1, 4, i == 4);

    // T6: drop enable for 10 cycles
    repeat (4) @(posedge clk_in);
    #1;
    enable = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    check("t6_locked_low", locked, 0);
    check("t6_half_period_held", half_period, 4);
    check("t6_state_idle", state_dbg, 0);
    check("t6_timeout_low", timeout, 0);
    enable = 1'b1;
    repeat (2) @(posedge clk_in);
    send_edge(4, 0, 0, 0);
    for (int i = 1; i <= 4; i++) send_edge(4, 1, 4, i == 4);
    drain();
    check("t6_relocked", locked, 1);
    repeat (4) @(posedge clk_in);
    #1;
    check("rise_pulse_count", rise_cnt, exp_rise);
    check("fall_pulse_count", fall_cnt, exp_fall);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
